// File: rtl/pixel_compositor.sv
// pixel_compositor: final video stage. Picks the highest-priority visible
// arena layer for each pixel, applies the sprite colour key and the player
// blink, and registers 12-bit RGB together with delayed hsync/vsync so that
// colour and sync leave the block aligned (2 pixel_tick latency).
//
// Ports:
//   clk, reset            system clock, async active-high reset
//   pixel_tick            one-clk pixel enable; pipeline advances only on it
//   video_on              active display area (0 forces black)
//   hsync_in, vsync_in    active-low syncs from the timing generator
//   <layer>_on/_rgb       layer hit and pixel for player, exp, bomb,
//                         block, pillar, wall; player_blink gates the player
//   rgb, hsync, vsync     registered VGA outputs
//   frame_cnt             counts vsync_in falling edges (free running)
module pixel_compositor #(
  parameter logic [11:0] TRANSP    = 12'hF0F,
  parameter logic [11:0] BG_RGB    = 12'h0A0,
  parameter int          BLINK_BIT = 3,
  parameter int          FCNT_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              player_on,
  input  logic [11:0]       player_rgb,
  input  logic              player_blink,
  input  logic              exp_on,
  input  logic [11:0]       exp_rgb,
  input  logic              bomb_on,
  input  logic [11:0]       bomb_rgb,
  input  logic              block_on,
  input  logic [11:0]       block_rgb,
  input  logic              pillar_on,
  input  logic [11:0]       pillar_rgb,
  input  logic              wall_on,
  input  logic [11:0]       wall_rgb,
  output logic [11:0]       rgb,
  output logic              hsync,
  output logic              vsync,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef struct packed {
    logic        video_on;
    logic        hs;
    logic        vs;
    logic        blink;
    logic        player_on;
    logic [11:0] player_rgb;
    logic        exp_on;
    logic [11:0] exp_rgb;
    logic        bomb_on;
    logic [11:0] bomb_rgb;
    logic        block_on;
    logic [11:0] block_rgb;
    logic        pillar_on;
    logic [11:0] pillar_rgb;
    logic        wall_on;
    logic [11:0] wall_rgb;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, vs_q;
  logic [FCNT_W-1:0] fc_q, fc_d;
  logic             vs_prev_q;

  // Stage 1 capture. Pixel data is zeroed when its layer is off so that
  // undriven/X colour buses on idle layers never enter the pipeline.
  always_comb begin
    s1_d            = '0;
    s1_d.video_on   = video_on;
    s1_d.hs         = hsync_in;
    s1_d.vs         = vsync_in;
    s1_d.blink      = player_blink;
    s1_d.player_on  = player_on;
    s1_d.player_rgb = player_on ? player_rgb : 12'h000;
    s1_d.exp_on     = exp_on;
    s1_d.exp_rgb    = exp_on    ? exp_rgb    : 12'h000;
    s1_d.bomb_on    = bomb_on;
    s1_d.bomb_rgb   = bomb_on   ? bomb_rgb   : 12'h000;
    s1_d.block_on   = block_on;
    s1_d.block_rgb  = block_on  ? block_rgb  : 12'h000;
    s1_d.pillar_on  = pillar_on;
    s1_d.pillar_rgb = pillar_on ? pillar_rgb : 12'h000;
    s1_d.wall_on    = wall_on;
    s1_d.wall_rgb   = wall_on   ? wall_rgb   : 12'h000;
  end

  // Stage 2 priority mux. Only the sprite layers honour the colour key;
  // a keyed-out or blinked-out sprite falls through to lower layers.
  logic player_vis, exp_vis, bomb_vis;

  always_comb begin
    player_vis = s1_q.player_on & (s1_q.player_rgb != TRANSP) &
                 ~(s1_q.blink & fc_q[BLINK_BIT]);
    exp_vis    = s1_q.exp_on  & (s1_q.exp_rgb  != TRANSP);
    bomb_vis   = s1_q.bomb_on & (s1_q.bomb_rgb != TRANSP);
    rgb_d      = BG_RGB;
    if (!s1_q.video_on)    rgb_d = 12'h000;
    else if (player_vis)   rgb_d = s1_q.player_rgb;
    else if (exp_vis)      rgb_d = s1_q.exp_rgb;
    else if (bomb_vis)     rgb_d = s1_q.bomb_rgb;
    else if (s1_q.block_on)  rgb_d = s1_q.block_rgb;
    else if (s1_q.pillar_on) rgb_d = s1_q.pillar_rgb;
    else if (s1_q.wall_on)   rgb_d = s1_q.wall_rgb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s1_q.hs <= 1'b1;
      s1_q.vs <= 1'b1;
      rgb_q   <= 12'h000;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else if (pixel_tick) begin
      s1_q  <= s1_d;
      rgb_q <= rgb_d;
      hs_q  <= s1_q.hs;
      vs_q  <= s1_q.vs;
    end
  end

  // Frame counter runs on every clk, independent of pixel_tick, so a
  // vsync edge is never missed between ticks.
  always_comb begin
    fc_d = fc_q;
    if (vs_prev_q && !vsync_in) fc_d = fc_q + FCNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc_q      <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      fc_q      <= fc_d;
      vs_prev_q <= vsync_in;
    end
  end

  assign rgb       = rgb_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign frame_cnt = fc_q;

endmodule

// File: tb/tb_pixel_compositor.sv
module tb_pixel_compositor;

  localparam logic [11:0] TRANSP = 12'hF0F;
  localparam logic [11:0] BG     = 12'h0A0;

  typedef struct packed {
    logic        video_on;
    logic        hs;
    logic        vs;
    logic        blink;
    logic        pl_on;
    logic [11:0] pl_rgb;
    logic        ex_on;
    logic [11:0] ex_rgb;
    logic        bm_on;
    logic [11:0] bm_rgb;
    logic        bk_on;
    logic [11:0] bk_rgb;
    logic        pr_on;
    logic [11:0] pr_rgb;
    logic        wl_on;
    logic [11:0] wl_rgb;
  } pin_t;

  typedef struct {
    pin_t        in;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  pin_t        cur;
  logic [11:0] rgb;
  logic        hsync, vsync;
  logic [5:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  pin_t        hist[$];
  logic [11:0] exp_rgb;
  logic        exp_hs, exp_vs;
  logic [5:0]  fc_m;
  logic        vs_prev_m;

  always #5 clk = ~clk;

  pixel_compositor dut (
    .clk(clk), .reset(rst), .pixel_tick(tick),
    .video_on(cur.video_on), .hsync_in(cur.hs), .vsync_in(cur.vs),
    .player_on(cur.pl_on), .player_rgb(cur.pl_rgb), .player_blink(cur.blink),
    .exp_on(cur.ex_on), .exp_rgb(cur.ex_rgb),
    .bomb_on(cur.bm_on), .bomb_rgb(cur.bm_rgb),
    .block_on(cur.bk_on), .block_rgb(cur.bk_rgb),
    .pillar_on(cur.pr_on), .pillar_rgb(cur.pr_rgb),
    .wall_on(cur.wl_on), .wall_rgb(cur.wl_rgb),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_cnt(frame_cnt)
  );

  // Colour a pixel from the layer rules, given the frame count in effect.
  function automatic logic [11:0] compose(input pin_t p, input logic [5:0] fc);
    if (!p.video_on) return 12'h000;
    if (p.pl_on && p.pl_rgb != TRANSP && !(p.blink && fc[3])) return p.pl_rgb;
    if (p.ex_on && p.ex_rgb != TRANSP) return p.ex_rgb;
    if (p.bm_on && p.bm_rgb != TRANSP) return p.bm_rgb;
    if (p.bk_on) return p.bk_rgb;
    if (p.pr_on) return p.pr_rgb;
    if (p.wl_on) return p.wl_rgb;
    return BG;
  endfunction

  function automatic pin_t base();
    pin_t p = '0;
    p.video_on = 1'b1;
    p.hs = 1'b1;
    p.vs = 1'b1;
    return p;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_rgb   = 12'h000;
    exp_hs    = 1'b1;
    exp_vs    = 1'b1;
    fc_m      = 6'd0;
    vs_prev_m = 1'b1;
  endtask

  // Output registered on a tick is the pixel captured on the previous tick,
  // coloured with the frame count held before this edge.
  task automatic model_step();
    if (tick) begin
      hist.push_back(cur);
      if (hist.size() > 2) void'(hist.pop_front());
      if (hist.size() == 2) begin
        exp_rgb = compose(hist[0], fc_m);
        exp_hs  = hist[0].hs;
        exp_vs  = hist[0].vs;
      end
    end
    if (vs_prev_m && !cur.vs) fc_m = fc_m + 6'd1;
    vs_prev_m = cur.vs;
  endtask

  // One clock with the given tick value; compare against the model after.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_rgb", int'(rgb), int'(exp_rgb));
    chk("model_hsync", int'(hsync), int'(exp_hs));
    chk("model_vsync", int'(vsync), int'(exp_vs));
    chk("model_fcnt", int'(frame_cnt), int'(fc_m));
  endtask

  // Async reset asserted between edges, checked before any clk edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_fcnt", int'(frame_cnt), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    cur = base();
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("init_rgb", int'(rgb), 0);
    chk("init_hsync", int'(hsync), 1);
    chk("init_fcnt", int'(frame_cnt), 0);
    rst = 1'b0;

    // ---- table vectors (frame_cnt stays 0: vsync held high) ----
    for (int i = 0; i < 12; i++) vecs[i].in = base();
    vecs[0].in.pr_on = 1; vecs[0].in.pr_rgb = 12'h888; vecs[0].exp = 12'h888;
    vecs[1].in.pl_on = 1; vecs[1].in.pl_rgb = TRANSP; vecs[1].in.bm_on = 1;
    vecs[1].in.bm_rgb = 12'h111; vecs[1].in.pr_on = 1; vecs[1].in.pr_rgb = 12'h888;
    vecs[1].exp = 12'h111;
    vecs[2].in = vecs[1].in; vecs[2].in.pl_rgb = 12'hFFF; vecs[2].exp = 12'hFFF;
    vecs[3].in.video_on = 0; vecs[3].in.pl_on = 1; vecs[3].in.pl_rgb = 12'hFFF;
    vecs[3].exp = 12'h000;
    vecs[4].exp = BG;
    vecs[5].in.ex_on = 1; vecs[5].in.ex_rgb = 12'h222; vecs[5].in.bm_on = 1;
    vecs[5].in.bm_rgb = 12'h333; vecs[5].exp = 12'h222;
    vecs[6].in.ex_on = 1; vecs[6].in.ex_rgb = TRANSP; vecs[6].in.bm_on = 1;
    vecs[6].in.bm_rgb = TRANSP; vecs[6].in.bk_on = 1; vecs[6].in.bk_rgb = 12'h555;
    vecs[6].exp = 12'h555;
    vecs[7].in.bk_on = 1; vecs[7].in.bk_rgb = TRANSP; vecs[7].in.wl_on = 1;
    vecs[7].in.wl_rgb = 12'h777; vecs[7].exp = TRANSP;
    vecs[8].in.pr_on = 1; vecs[8].in.pr_rgb = 12'h666; vecs[8].in.wl_on = 1;
    vecs[8].in.wl_rgb = 12'h777; vecs[8].exp = 12'h666;
    vecs[9].in.wl_on = 1; vecs[9].in.wl_rgb = 12'h777; vecs[9].in.hs = 0;
    vecs[9].exp = 12'h777;
    vecs[10].in.blink = 1; vecs[10].in.pl_on = 1; vecs[10].in.pl_rgb = 12'hFFF;
    vecs[10].in.wl_on = 1; vecs[10].in.wl_rgb = 12'h444; vecs[10].exp = 12'hFFF;
    vecs[11].in.pl_on = 1; vecs[11].in.pl_rgb = TRANSP; vecs[11].in.ex_on = 1;
    vecs[11].in.ex_rgb = 12'hABC; vecs[11].exp = 12'hABC;

    for (int i = 0; i < 12; i++) begin
      cur = vecs[i].in;
      cyc(1);
      cyc(1);
      chk($sformatf("vec%0d_rgb", i), int'(rgb), int'(vecs[i].exp));
      chk($sformatf("vec%0d_hsync", i), int'(hsync), int'(vecs[i].in.hs));
    end

    // ---- exact 2-tick latency for colour and sync ----
    cur = base();
    cyc(1); cyc(1);
    cur.pr_on = 1; cur.pr_rgb = 12'h888; cur.hs = 0; cur.vs = 1;
    cyc(1);
    chk("lat1_rgb", int'(rgb), int'(BG));
    chk("lat1_hsync", int'(hsync), 1);
    cur = base();
    cyc(1);
    chk("lat2_rgb", int'(rgb), 12'h888);
    chk("lat2_hsync", int'(hsync), 0);

    // ---- tick gating ----
    cur = base(); cur.pr_on = 1; cur.pr_rgb = 12'h888;
    cyc(1); cyc(1);
    cur.pr_rgb = 12'h123; cur.hs = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0);
      chk("gate_rgb", int'(rgb), 12'h888);
      chk("gate_hsync", int'(hsync), 1);
    end
    cyc(1);
    chk("resume1_rgb", int'(rgb), 12'h888);
    cyc(1);
    chk("resume2_rgb", int'(rgb), 12'h123);
    chk("resume2_hsync", int'(hsync), 0);

    // ---- blink and frame counter wrap ----
    cur = base();
    cyc(1);
    do_reset();
    cur = base(); cur.blink = 1; cur.pl_on = 1; cur.pl_rgb = 12'hFFF;
    cur.wl_on = 1; cur.wl_rgb = 12'h444;
    for (int k = 0; k < 64; k++) begin
      cyc(1); cyc(1); cyc(1);
      chk("blink_fcnt", int'(frame_cnt), k);
      if (k < 16) chk($sformatf("blink_f%0d", k), int'(rgb), (k >= 8) ? 12'h444 : 12'hFFF);
      cur.vs = 0;
      cyc(1);
      cur.vs = 1;
      cyc(1);
    end
    chk("wrap_fcnt", int'(frame_cnt), 0);

    // ---- vsync edge on a non-tick cycle still counts ----
    cur.vs = 0;
    cyc(0);
    cur.vs = 1;
    cyc(0);
    chk("notick_fcnt", int'(frame_cnt), 1);

    // ---- randomized against the model ----
    for (int n = 0; n < 3000; n++) begin
      pin_t p;
      p.video_on = ($urandom_range(0, 7) != 0);
      p.hs       = ($urandom_range(0, 7) != 0);
      p.vs       = ($urandom_range(0, 9) != 0);
      p.blink    = 1'($urandom_range(0, 1));
      p.pl_on    = ($urandom_range(0, 2) == 0);
      p.pl_rgb   = ($urandom_range(0, 3) == 0) ? TRANSP : 12'($urandom);
      p.ex_on    = ($urandom_range(0, 2) == 0);
      p.ex_rgb   = ($urandom_range(0, 3) == 0) ? TRANSP : 12'($urandom);
      p.bm_on    = ($urandom_range(0, 2) == 0);
      p.bm_rgb   = ($urandom_range(0, 3) == 0) ? TRANSP : 12'($urandom);
      p.bk_on    = ($urandom_range(0, 2) == 0);
      p.bk_rgb   = ($urandom_range(0, 5) == 0) ? TRANSP : 12'($urandom);
      p.pr_on    = ($urandom_range(0, 2) == 0);
      p.pr_rgb   = 12'($urandom);
      p.wl_on    = ($urandom_range(0, 2) == 0);
      p.wl_rgb   = 12'($urandom);
      cur = p;
      cyc(1'($urandom_range(0, 1)));
    end

    // ---- async reset mid-frame, then first pixel after 2 ticks ----
    do_reset();
    cur = base(); cur.pr_on = 1; cur.pr_rgb = 12'h888; cur.hs = 0;
    cyc(1);
    chk("post_rst1_rgb", int'(rgb), 0);
    chk("post_rst1_hsync", int'(hsync), 1);
    cyc(1);
    chk("post_rst2_rgb", int'(rgb), 12'h888);
    chk("post_rst2_hsync", int'(hsync), 0);
    cyc(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
